// File: rtl/result_bus_arbiter_pkg.sv
// rtl/result_bus_arbiter_pkg.sv - shared constants for the result bus arbiter
// Contents: default ROB tag width, result-source encodings used on cdb_src,
// number of sources, and the round-robin successor function.
package result_bus_arbiter_pkg;

    localparam int ROB_WIDTH_DEFAULT = 4;
    localparam int NUM_CDB_SRC       = 3;

    localparam logic [1:0] SRC_ALU1 = 2'd0;
    localparam logic [1:0] SRC_ALU2 = 2'd1;
    localparam logic [1:0] SRC_LSB  = 2'd2;

    // Successor of source k in the three-way rotation (k+1 mod 3).
    function automatic logic [1:0] next_src(input logic [1:0] k);
        return (k >= SRC_LSB) ? SRC_ALU1 : k + 2'd1;
    endfunction

endpackage

// File: rtl/result_bus_arbiter_if.sv
// rtl/result_bus_arbiter_if.sv - result sources / common data bus interface
// master: driven by the pipeline (control, source offers), observes ready/cdb_*.
// slave : the arbiter; consumes offers and control, drives ready/cdb_*/conflict_cnt.
interface result_bus_arbiter_if #(
    parameter int ROB_WIDTH = result_bus_arbiter_pkg::ROB_WIDTH_DEFAULT
) ();
    import result_bus_arbiter_pkg::*;

    logic                 rdy_in;
    logic                 clear_signal;

    logic                 valid_alu_1;
    logic                 valid_alu_2;
    logic                 valid_lsb;
    logic [31:0]          value_alu_1;
    logic [31:0]          value_alu_2;
    logic [31:0]          value_lsb;
    logic [ROB_WIDTH-1:0] tag_alu_1;
    logic [ROB_WIDTH-1:0] tag_alu_2;
    logic [ROB_WIDTH-1:0] tag_lsb;
    logic                 ready_alu_1;
    logic                 ready_alu_2;
    logic                 ready_lsb;

    logic                 cdb_valid;
    logic [31:0]          cdb_value;
    logic [ROB_WIDTH-1:0] cdb_tag;
    logic [1:0]           cdb_src;
    logic [31:0]          conflict_cnt;

    modport master (
        output rdy_in, clear_signal,
        output valid_alu_1, valid_alu_2, valid_lsb,
        output value_alu_1, value_alu_2, value_lsb,
        output tag_alu_1, tag_alu_2, tag_lsb,
        input  ready_alu_1, ready_alu_2, ready_lsb,
        input  cdb_valid, cdb_value, cdb_tag, cdb_src, conflict_cnt
    );

    modport slave (
        input  rdy_in, clear_signal,
        input  valid_alu_1, valid_alu_2, valid_lsb,
        input  value_alu_1, value_alu_2, value_lsb,
        input  tag_alu_1, tag_alu_2, tag_lsb,
        output ready_alu_1, ready_alu_2, ready_lsb,
        output cdb_valid, cdb_value, cdb_tag, cdb_src, conflict_cnt
    );

endinterface

// File: rtl/result_bus_arbiter_cdb_rr_arbiter.sv
// rtl/result_bus_arbiter_cdb_rr_arbiter.sv - combinational 3-way grant selector
// Ports: i_req (request per source), i_ptr (first source to consider),
//        o_gnt (one-hot grant), o_gnt_idx (encoded granted source).
// With i_ptr tied to SRC_ALU1 this degenerates to fixed priority ALU1>ALU2>LSB.
module cdb_rr_arbiter
    import result_bus_arbiter_pkg::*;
(
    input  logic [NUM_CDB_SRC-1:0] i_req,
    input  logic [1:0]             i_ptr,
    output logic [NUM_CDB_SRC-1:0] o_gnt,
    output logic [1:0]             o_gnt_idx
);

    always_comb begin
        logic [1:0] w_cand;
        logic       w_found;
        o_gnt     = '0;
        o_gnt_idx = SRC_ALU1;
        w_found   = 1'b0;
        // An out-of-range pointer restarts the scan at ALU1.
        w_cand    = (i_ptr > SRC_LSB) ? SRC_ALU1 : i_ptr;
        for (int i = 0; i < NUM_CDB_SRC; i++) begin
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_gnt[w_cand]   = 1'b1;
                o_gnt_idx       = w_cand;
            end
            w_cand = next_src(w_cand);
        end
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// rtl/result_bus_arbiter.sv - three-source result bus (CDB) arbiter
// Ports: clk_in, rst_in (synchronous, active-high), bus (slave modport):
//   rdy_in freezes all state when low; clear_signal flushes pending entries;
//   valid/value/tag_x offers with ready_x back-pressure; cdb_* registered
//   broadcast; conflict_cnt counts cycles with two or more pending entries.
// Macro CDB_ROUND_ROBIN_EN: round-robin grant with a rotating pointer;
//   undefined gives fixed priority ALU1 > ALU2 > LSB and no pointer register.
module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    result_bus_arbiter_if.slave  bus
);

    logic [NUM_CDB_SRC-1:0] r_pend_valid;
    logic [31:0]            r_pend_value [NUM_CDB_SRC];
    logic [ROB_WIDTH-1:0]   r_pend_tag   [NUM_CDB_SRC];

    logic                   r_cdb_valid;
    logic [31:0]            r_cdb_value;
    logic [ROB_WIDTH-1:0]   r_cdb_tag;
    logic [1:0]             r_cdb_src;
    logic [31:0]            r_conflict_cnt;

    logic [NUM_CDB_SRC-1:0] w_in_valid;
    logic [31:0]            w_in_value [NUM_CDB_SRC];
    logic [ROB_WIDTH-1:0]   w_in_tag   [NUM_CDB_SRC];
    logic [NUM_CDB_SRC-1:0] w_ready;
    logic [NUM_CDB_SRC-1:0] w_accept;
    logic [NUM_CDB_SRC-1:0] w_gnt;
    logic [1:0]             w_gnt_idx;
    logic [1:0]             w_ptr;
    logic                   w_any_gnt;
    logic                   w_conflict;
    logic [31:0]            w_gnt_value;
    logic [ROB_WIDTH-1:0]   w_gnt_tag;

    assign w_in_valid    = {bus.valid_lsb, bus.valid_alu_2, bus.valid_alu_1};
    assign w_in_value[0] = bus.value_alu_1;
    assign w_in_value[1] = bus.value_alu_2;
    assign w_in_value[2] = bus.value_lsb;
    assign w_in_tag[0]   = bus.tag_alu_1;
    assign w_in_tag[1]   = bus.tag_alu_2;
    assign w_in_tag[2]   = bus.tag_lsb;

    cdb_rr_arbiter u_arb (
        .i_req     (r_pend_valid),
        .i_ptr     (w_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_any_gnt  = |w_gnt;
    assign w_conflict = (r_pend_valid[0] & r_pend_valid[1]) |
                        (r_pend_valid[0] & r_pend_valid[2]) |
                        (r_pend_valid[1] & r_pend_valid[2]);

    // A slot can take a new offer when empty or when it is being drained this edge.
    assign w_ready  = {NUM_CDB_SRC{bus.rdy_in & ~bus.clear_signal}} & (~r_pend_valid | w_gnt);
    assign w_accept = w_in_valid & w_ready;

    always_comb begin
        w_gnt_value = r_pend_value[0];
        w_gnt_tag   = r_pend_tag[0];
        case (w_gnt_idx)
            SRC_ALU2: begin
                w_gnt_value = r_pend_value[1];
                w_gnt_tag   = r_pend_tag[1];
            end
            SRC_LSB: begin
                w_gnt_value = r_pend_value[2];
                w_gnt_tag   = r_pend_tag[2];
            end
            default: ;
        endcase
    end

`ifdef CDB_ROUND_ROBIN_EN
    logic [1:0] r_rr_ptr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rr_ptr <= SRC_ALU1;
        end else if (bus.rdy_in && !bus.clear_signal && w_any_gnt) begin
            r_rr_ptr <= next_src(w_gnt_idx);
        end
    end

    assign w_ptr = r_rr_ptr;
`else
    assign w_ptr = SRC_ALU1;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pend_valid <= '0;
            for (int i = 0; i < NUM_CDB_SRC; i++) begin
                r_pend_value[i] <= '0;
                r_pend_tag[i]   <= '0;
            end
            r_cdb_valid    <= 1'b0;
            r_cdb_value    <= '0;
            r_cdb_tag      <= '0;
            r_cdb_src      <= SRC_ALU1;
            r_conflict_cnt <= '0;
        end else if (bus.rdy_in) begin
            if (bus.clear_signal) begin
                r_pend_valid <= '0;
                r_cdb_valid  <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_CDB_SRC; i++) begin
                    // A new offer on the granted slot reloads it instead of emptying it.
                    if (w_accept[i]) begin
                        r_pend_valid[i] <= 1'b1;
                        r_pend_value[i] <= w_in_value[i];
                        r_pend_tag[i]   <= w_in_tag[i];
                    end else if (w_gnt[i]) begin
                        r_pend_valid[i] <= 1'b0;
                    end
                end
                r_cdb_valid <= w_any_gnt;
                if (w_any_gnt) begin
                    r_cdb_value <= w_gnt_value;
                    r_cdb_tag   <= w_gnt_tag;
                    r_cdb_src   <= w_gnt_idx;
                end
                if (w_conflict) begin
                    r_conflict_cnt <= r_conflict_cnt + 32'd1;
                end
            end
        end
    end

    assign bus.ready_alu_1  = w_ready[0];
    assign bus.ready_alu_2  = w_ready[1];
    assign bus.ready_lsb    = w_ready[2];
    assign bus.cdb_valid    = r_cdb_valid;
    assign bus.cdb_value    = r_cdb_value;
    assign bus.cdb_tag      = r_cdb_tag;
    assign bus.cdb_src      = r_cdb_src;
    assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb/tb_result_bus_arbiter.sv - scoreboard bench for result_bus_arbiter
module tb_result_bus_arbiter;
    import result_bus_arbiter_pkg::*;

    localparam int RW = ROB_WIDTH_DEFAULT;

    typedef struct {
        logic [1:0]    src;
        logic [31:0]   value;
        logic [RW-1:0] tag;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_bus_arbiter_if #(.ROB_WIDTH(RW)) bus ();

    result_bus_arbiter #(.ROB_WIDTH(RW)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    logic [2:0]    tb_valid;
    logic [31:0]   tb_value [3];
    logic [RW-1:0] tb_tag   [3];
    logic [2:0]    tb_ready;

    assign bus.valid_alu_1 = tb_valid[0];
    assign bus.valid_alu_2 = tb_valid[1];
    assign bus.valid_lsb   = tb_valid[2];
    assign bus.value_alu_1 = tb_value[0];
    assign bus.value_alu_2 = tb_value[1];
    assign bus.value_lsb   = tb_value[2];
    assign bus.tag_alu_1   = tb_tag[0];
    assign bus.tag_alu_2   = tb_tag[1];
    assign bus.tag_lsb     = tb_tag[2];
    assign tb_ready        = {bus.ready_lsb, bus.ready_alu_2, bus.ready_alu_1};

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t script_q [$];
    ent_t exp_q    [$];
    int   src_log  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int s, input logic [31:0] v, input int t);
        ent_t e;
        e.src   = 2'(s);
        e.value = v;
        e.tag   = RW'(t);
        script_q.push_back(e);
    endtask

    // One clock: present each source's oldest unsent entry, hold it until accepted.
    task automatic step();
        logic [2:0] acc;
        int         head [3];
        for (int s = 0; s < 3; s++) begin
            head[s] = -1;
            for (int k = 0; k < script_q.size(); k++)
                if (head[s] < 0 && int'(script_q[k].src) == s) head[s] = k;
            if (head[s] >= 0) begin
                tb_valid[s] = 1'b1;
                tb_value[s] = script_q[head[s]].value;
                tb_tag[s]   = script_q[head[s]].tag;
            end else begin
                tb_valid[s] = 1'b0;
            end
        end
        #1;
        acc = tb_valid & tb_ready & {3{~rst}};
        @(posedge clk);
        for (int k = script_q.size() - 1; k >= 0; k--) begin
            bit hit;
            hit = 1'b0;
            for (int s = 0; s < 3; s++)
                if (acc[s] && head[s] == k) hit = 1'b1;
            if (hit) begin
                exp_q.push_back(script_q[k]);
                script_q.delete(k);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        tb_valid = 3'b000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        src_log.delete();
    endtask

    task automatic check_log3(input string name, input int a, input int b, input int c);
        check({name, "_len"}, 32'(src_log.size()), 32'd3);
        if (src_log.size() >= 3) begin
            check({name, "_0"}, 32'(src_log[0]), 32'(a));
            check({name, "_1"}, 32'(src_log[1]), 32'(b));
            check({name, "_2"}, 32'(src_log[2]), 32'(c));
        end
    endtask

    task automatic check_drained(input string name);
        check({name, "_script_left"}, 32'(script_q.size()), 32'd0);
        check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every edge taken with rdy_in=1 and no reset that leaves cdb_valid=1
    // is one broadcast; it must match the oldest outstanding entry of that source.
    initial begin
        forever begin
            logic e_rdy;
            logic e_rst;
            int   idx;
            @(posedge clk);
            e_rdy = bus.rdy_in;
            e_rst = rst;
            #1;
            if (!e_rst && e_rdy && bus.cdb_valid === 1'b1) begin
                src_log.push_back(int'(bus.cdb_src));
                idx = -1;
                for (int k = 0; k < exp_q.size(); k++)
                    if (idx < 0 && exp_q[k].src == bus.cdb_src) idx = k;
                n_tests++;
                if (idx < 0) begin
                    n_fail++;
                    $display("FAIL cdb_unexpected: got src %0d value 0x%0h tag %0d, required no broadcast",
                             bus.cdb_src, bus.cdb_value, bus.cdb_tag);
                end else begin
                    if (bus.cdb_value !== exp_q[idx].value || bus.cdb_tag !== exp_q[idx].tag) begin
                        n_fail++;
                        $display("FAIL cdb_payload src %0d: got 0x%0h/%0d required 0x%0h/%0d", bus.cdb_src,
                                 bus.cdb_value, bus.cdb_tag, exp_q[idx].value, exp_q[idx].tag);
                    end
                    exp_q.delete(idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          s_valid;
        logic [31:0]   s_value;
        logic [RW-1:0] s_tag;
        logic [1:0]    s_src;
        logic [31:0]   s_cnt;

        bus.rdy_in       = 1'b1;
        bus.clear_signal = 1'b0;
        tb_valid         = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tb_value[i] = '0;
            tb_tag[i]   = '0;
        end
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check("rst_cdb_value", bus.cdb_value, 32'd0);
        check("rst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
        check("rst_cdb_src", 32'(bus.cdb_src), 32'd0);
        check("rst_conflict", bus.conflict_cnt, 32'd0);
        check("rst_ready", 32'(tb_ready), 32'h7);

        // Single offer: two-edge latency, ready stays high
        do_reset();
        add(0, 32'h1234, 5);
        check("single_ready_c1", 32'(tb_ready[0]), 32'd1);
        step();
        check("single_valid_c2", 32'(bus.cdb_valid), 32'd0);
        check("single_ready_c2", 32'(tb_ready[0]), 32'd1);
        step();
        check("single_valid_c3", 32'(bus.cdb_valid), 32'd1);
        check("single_src_c3", 32'(bus.cdb_src), 32'd0);
        check("single_ready_c3", 32'(tb_ready[0]), 32'd1);
        step();
        check("single_valid_c4", 32'(bus.cdb_valid), 32'd0);
        check("single_value_hold", bus.cdb_value, 32'h1234);
        check("single_tag_hold", 32'(bus.cdb_tag), 32'd5);
        check_drained("single");

        // Three-way contention
        do_reset();
        add(0, 32'hA1, 1);
        add(1, 32'hA2, 2);
        add(2, 32'hB3, 3);
        drain(6);
        check_log3("contend_order", 0, 1, 2);
        check("contend_conflict", bus.conflict_cnt, 32'd2);
        check_drained("contend");

        // Back-pressure: ALU1 re-offers every cycle while ALU2 keeps offering
        do_reset();
        for (int i = 0; i < 6; i++) add(0, 32'h100 + 32'(i), i);
        for (int i = 0; i < 3; i++) add(1, 32'h200 + 32'(i), 8 + i);
        step();
        check("bp_ready2_after_capture", 32'(tb_ready[1]), 32'd0);
`ifndef CDB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_ready2_blocked", 32'(tb_ready[1]), 32'd0);
        end
`endif
        drain(20);
        check("bp_broadcasts", 32'(src_log.size()), 32'd9);
        check_drained("bp");

        // Flush: pending ALU1 tag 3 and LSB tag 7 never broadcast
        do_reset();
        add(0, 32'h33, 3);
        add(2, 32'h77, 7);
        step();
        bus.clear_signal = 1'b1;
        #1;
        check("flush_ready", 32'(tb_ready), 32'd0);
        step();
        bus.clear_signal = 1'b0;
        check("flush_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check("flush_conflict", bus.conflict_cnt, 32'd0);
        exp_q.delete();
        drain(4);
        check("flush_broadcasts", 32'(src_log.size()), 32'd0);
        check_drained("flush");

        // Stall mid-contention
        do_reset();
        add(0, 32'hC1, 4);
        add(1, 32'hC2, 6);
        add(2, 32'hC3, 2);
        step();
        step();
        bus.rdy_in = 1'b0;
        s_valid = bus.cdb_valid;
        s_value = bus.cdb_value;
        s_tag   = bus.cdb_tag;
        s_src   = bus.cdb_src;
        s_cnt   = bus.conflict_cnt;
        check("stall_snap_valid", 32'(s_valid), 32'd1);
        check("stall_snap_value", s_value, 32'hC1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_valid", 32'(bus.cdb_valid), 32'(s_valid));
            check("stall_value", bus.cdb_value, s_value);
            check("stall_tag", 32'(bus.cdb_tag), 32'(s_tag));
            check("stall_src", 32'(bus.cdb_src), 32'(s_src));
            check("stall_conflict", bus.conflict_cnt, s_cnt);
            check("stall_ready", 32'(tb_ready), 32'd0);
        end
        bus.rdy_in = 1'b1;
        drain(5);
        check_log3("stall_order", 0, 1, 2);
        check("stall_conflict_end", bus.conflict_cnt, 32'd2);
        check_drained("stall");

        // Reset mid-operation with two entries pending and an offer during reset
        do_reset();
        add(0, 32'hD1, 1);
        add(1, 32'hD2, 2);
        add(2, 32'hD3, 3);
        step();
        step();
        rst         = 1'b1;
        tb_valid    = 3'b001;
        tb_value[0] = 32'hDEAD;
        tb_tag[0]   = RW'(9);
        @(negedge clk);
        rst      = 1'b0;
        tb_valid = 3'b000;
        check("mrst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check("mrst_cdb_value", bus.cdb_value, 32'd0);
        check("mrst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
        check("mrst_cdb_src", 32'(bus.cdb_src), 32'd0);
        check("mrst_conflict", bus.conflict_cnt, 32'd0);
        check("mrst_ready", 32'(tb_ready), 32'h7);
        exp_q.delete();
        src_log.delete();
        drain(3);
        check("mrst_no_broadcast", 32'(src_log.size()), 32'd0);
        add(0, 32'hE1, 10);
        add(1, 32'hE2, 11);
        add(2, 32'hE3, 12);
        drain(6);
        check_log3("mrst_order", 0, 1, 2);
        check_drained("mrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
